// File: rtl/bram_write_sequencer_if.sv
// Control and status bundle between a capture controller and the BRAM write sequencer.
// The sequencer takes the slave view; whoever drives restart/abort/config takes the master view.
interface bram_write_sequencer_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int NPER_WIDTH = 16
);
    logic                  restart;
    logic                  abort;
    logic                  continuous;
    logic [NPER_WIDTH-1:0] n_periods;
    logic [ADDR_WIDTH-1:0] count_max;
    logic [ADDR_WIDTH-1:0] address;

    logic                  wen;
    logic [ADDR_WIDTH-1:0] count;
    logic [NPER_WIDTH-1:0] period_idx;
    logic                  first;
    logic                  init;
    logic                  done;
    logic                  busy;

    modport master (
        output restart, abort, continuous, n_periods, count_max, address,
        input  wen, count, period_idx, first, init, done, busy
    );

    modport slave (
        input  restart, abort, continuous, n_periods, count_max, address,
        output wen, count, period_idx, first, init, done, busy
    );
endinterface

// File: rtl/bram_write_sequencer.sv
// Generates BRAM write enable/address for blocks of periods, synchronised to a free-running address.
// Config is captured on restart; all outputs come straight from registers.
module bram_write_sequencer #(
    parameter int ADDR_WIDTH = 13,
    parameter int NPER_WIDTH = 16,
    parameter int INIT_LEAD  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    bram_write_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LEAD = ADDR_WIDTH'(INIT_LEAD);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cm_reg;
    logic [NPER_WIDTH-1:0] np_reg;
    logic                  cont_reg;

    logic                  lead_ok;
    logic [ADDR_WIDTH-1:0] init_pt;
    logic [ADDR_WIDTH-1:0] count_inc;
    logic                  last_addr;
    logic                  last_period;
    logic                  init_next;
    logic                  init_zero;

    // init is registered, so it is decided from the count value about to be loaded.
    assign lead_ok     = (cm_reg >= LEAD);
    assign init_pt     = cm_reg - LEAD;
    assign count_inc   = bus.count + ADDR_WIDTH'(1);
    assign last_addr   = (bus.count == cm_reg);
    assign last_period = (bus.period_idx == np_reg - NPER_WIDTH'(1));
    assign init_next   = lead_ok && (count_inc == init_pt);
    assign init_zero   = lead_ok && (init_pt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cm_reg         <= '0;
            np_reg         <= NPER_WIDTH'(1);
            cont_reg       <= 1'b0;
            bus.wen        <= 1'b0;
            bus.count      <= '0;
            bus.period_idx <= '0;
            bus.first      <= 1'b0;
            bus.init       <= 1'b0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b0;
        end else if (bus.abort) begin
            state     <= IDLE;
            bus.wen   <= 1'b0;
            bus.first <= 1'b0;
            bus.init  <= 1'b0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
        end else if (bus.restart) begin
            state          <= ARM;
            cm_reg         <= bus.count_max;
            np_reg         <= (bus.n_periods == '0) ? NPER_WIDTH'(1) : bus.n_periods;
            cont_reg       <= bus.continuous;
            bus.wen        <= 1'b0;
            bus.count      <= '0;
            bus.period_idx <= '0;
            bus.first      <= 1'b0;
            bus.init       <= 1'b0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: ;
                ARM: begin
                    if (bus.address == cm_reg) begin
                        state          <= RUN;
                        bus.wen        <= 1'b1;
                        bus.count      <= '0;
                        bus.period_idx <= '0;
                        bus.first      <= 1'b1;
                        bus.init       <= init_zero;
                    end
                end
                RUN: begin
                    if (!last_addr) begin
                        bus.count <= count_inc;
                        bus.init  <= init_next;
                    end else if (!last_period) begin
                        bus.count      <= '0;
                        bus.period_idx <= bus.period_idx + NPER_WIDTH'(1);
                        bus.first      <= 1'b0;
                        bus.init       <= init_zero;
                    end else begin
                        bus.done <= 1'b1;
                        if (cont_reg) begin
                            bus.count      <= '0;
                            bus.period_idx <= '0;
                            bus.first      <= 1'b1;
                            bus.init       <= init_zero;
                        end else begin
                            // count stays parked on the last address of the block
                            state     <= IDLE;
                            bus.wen   <= 1'b0;
                            bus.first <= 1'b0;
                            bus.init  <= 1'b0;
                            bus.busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_write_sequencer.sv
// Directed testbench for bram_write_sequencer with hand-computed expected output vectors.
module tb_bram_write_sequencer;
    localparam int AW = 13;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   addr_period = 8;

    always #5 clk = ~clk;

    bram_write_sequencer_if #(.ADDR_WIDTH(AW), .NPER_WIDTH(NW)) bus ();

    bram_write_sequencer #(.ADDR_WIDTH(AW), .NPER_WIDTH(NW), .INIT_LEAD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed view {wen, first, init, done, busy, period_idx, count}.
    function automatic logic [33:0] obs();
        return {bus.wen, bus.first, bus.init, bus.done, bus.busy, bus.period_idx, bus.count};
    endfunction

    function automatic logic [33:0] exp_vec(bit wen, bit first, bit init, bit done, bit busy,
                                            int pidx, int cnt);
        return {wen, first, init, done, busy, NW'(pidx), AW'(cnt)};
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.address = (int'(bus.address) >= addr_period - 1) ? '0 : bus.address + AW'(1);
    endtask

    task automatic start(int cm, int np, bit cont);
        bus.count_max  = AW'(cm);
        bus.n_periods  = NW'(np);
        bus.continuous = cont;
        bus.restart    = 1'b1;
        tick();
        bus.restart    = 1'b0;
    endtask

    task automatic wait_wen(int max, output int ticks, output bit ok);
        ticks = 0;
        ok    = 1'b0;
        while (ticks < max) begin
            if (bus.wen === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            ticks++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_wen: wen not seen within %0d cycles", max);
        end
    endtask

    task automatic run_block(int max, output int wen_cnt, output int init_cnt, output int done_cnt);
        wen_cnt  = 0;
        init_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < max; i++) begin
            wen_cnt  += int'(bus.wen);
            init_cnt += int'(bus.init);
            if (bus.done === 1'b1) begin
                done_cnt++;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [33:0] e;
        rst            = 1'b1;
        bus.restart    = 1'b0;
        bus.abort      = 1'b0;
        bus.continuous = 1'b0;
        bus.n_periods  = '0;
        bus.count_max  = '0;
        bus.address    = '0;
        tick();
        tick();
        e = exp_vec(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs(), e);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL reset_idle_hold: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_single_block();
        logic [33:0] e;
        int t;
        bit ok;
        addr_period = 8;
        bus.address = '0;
        start(7, 1, 0);
        e = exp_vec(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL single_arm: got %h expected %h", obs(), e);
        end
        wait_wen(20, t, ok);
        checks++;
        if (t != 7) begin
            failures++;
            $display("[TB] FAIL single_sync_latency: got %0d expected 7", t);
        end
        for (int k = 0; k < 8; k++) begin
            e = exp_vec(1, 1, k == 5, 0, 1, 0, k);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("[TB] FAIL single_run k=%0d: got %h expected %h", k, obs(), e);
            end
            tick();
        end
        e = exp_vec(0, 0, 0, 1, 0, 0, 7);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL single_done: got %h expected %h", obs(), e);
        end
        tick();
        e = exp_vec(0, 0, 0, 0, 0, 0, 7);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL single_after_done: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_multi_period();
        logic [33:0] e;
        int t;
        bit ok;
        addr_period = 8;
        bus.address = '0;
        start(3, 3, 0);
        wait_wen(20, t, ok);
        for (int k = 0; k < 12; k++) begin
            e = exp_vec(1, k < 4, (k % 4) == 1, 0, 1, k / 4, k % 4);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("[TB] FAIL multi_run k=%0d: got %h expected %h", k, obs(), e);
            end
            tick();
        end
        e = exp_vec(0, 0, 0, 1, 0, 2, 3);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL multi_done: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_continuous_abort();
        logic [33:0] e;
        int t;
        int dones;
        int wens;
        bit ok;
        addr_period = 8;
        bus.address = '0;
        start(3, 2, 1);
        wait_wen(20, t, ok);
        for (int k = 0; k < 20; k++) begin
            e = exp_vec(1, ((k / 4) % 2) == 0, (k % 4) == 1, (k > 0) && ((k % 8) == 0), 1,
                        (k / 4) % 2, k % 4);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("[TB] FAIL cont_run k=%0d: got %h expected %h", k, obs(), e);
            end
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.wen, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL abort_stop: got wen/busy/done=%b expected 000",
                     {bus.wen, bus.busy, bus.done});
        end
        dones = 0;
        wens  = 0;
        for (int k = 0; k < 12; k++) begin
            dones += int'(bus.done);
            wens  += int'(bus.wen);
            tick();
        end
        checks++;
        if (dones != 0 || wens != 0) begin
            failures++;
            $display("[TB] FAIL abort_quiet: got done=%0d wen=%0d expected 0 0", dones, wens);
        end
        bus.abort   = 1'b1;
        bus.restart = 1'b1;
        tick();
        bus.abort   = 1'b0;
        bus.restart = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_beats_restart: got busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_boundaries();
        int t;
        int w;
        int i;
        int d;
        bit ok;
        logic [33:0] e;
        addr_period = 8;
        bus.address = '0;
        start(1, 2, 0);
        wait_wen(20, t, ok);
        run_block(20, w, i, d);
        checks++;
        if (w != 4 || i != 0 || d != 1) begin
            failures++;
            $display("[TB] FAIL short_period_no_init: got wen=%0d init=%0d done=%0d expected 4 0 1",
                     w, i, d);
        end
        start(0, 0, 0);
        wait_wen(20, t, ok);
        run_block(20, w, i, d);
        checks++;
        if (w != 1 || i != 0 || d != 1) begin
            failures++;
            $display("[TB] FAIL zero_len: got wen=%0d init=%0d done=%0d expected 1 0 1", w, i, d);
        end
        e = exp_vec(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL zero_len_done: got %h expected %h", obs(), e);
        end
        start(2, 1, 0);
        wait_wen(20, t, ok);
        run_block(20, w, i, d);
        checks++;
        if (w != 3 || i != 1 || d != 1) begin
            failures++;
            $display("[TB] FAIL init_at_zero: got wen=%0d init=%0d done=%0d expected 3 1 1", w, i, d);
        end
    endtask

    task automatic test_restart_in_run();
        logic [33:0] e;
        int t;
        bit ok;
        addr_period = 16;
        bus.address = '0;
        start(7, 1, 1);
        wait_wen(40, t, ok);
        tick();
        tick();
        tick();
        start(15, 1, 0);
        e = exp_vec(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL rearm: got %h expected %h", obs(), e);
        end
        bus.count_max  = AW'(3);
        bus.n_periods  = NW'(5);
        bus.continuous = 1'b1;
        wait_wen(40, t, ok);
        checks++;
        if (bus.address !== AW'(0)) begin
            failures++;
            $display("[TB] FAIL rearm_sync: got next address %0d expected 0", bus.address);
        end
        for (int k = 0; k < 16; k++) begin
            e = exp_vec(1, 1, k == 13, 0, 1, 0, k);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("[TB] FAIL rearm_run k=%0d: got %h expected %h", k, obs(), e);
            end
            tick();
        end
        e = exp_vec(0, 0, 0, 1, 0, 0, 15);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL rearm_done: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [33:0] e;
        int t;
        bit ok;
        addr_period = 8;
        bus.address = '0;
        start(7, 2, 0);
        wait_wen(20, t, ok);
        tick();
        tick();
        rst = 1'b1;
        tick();
        e = exp_vec(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL reset_mid_run: got %h expected %h", obs(), e);
        end
        rst = 1'b0;
        start(7, 2, 0);
        rst         = 1'b1;
        bus.restart = 1'b1;
        tick();
        rst         = 1'b0;
        bus.restart = 1'b0;
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL reset_with_restart: got %h expected %h", obs(), e);
        end
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("[TB] FAIL reset_stays_idle: got %h expected %h", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_period();
        test_continuous_abort();
        test_boundaries();
        test_restart_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/bram_write_sequencer.md
BRAM_WRITE_SEQUENCER -- requirements
Module: bram_write_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, SHALL set the BRAM address/count width.
REQ-002 Parameter NPER_WIDTH, default 16, SHALL set the period-count width.
REQ-003 Parameter INIT_LEAD, default 2, SHALL set how many cycles before period end init pulses.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 restart  in  1  single-cycle request to latch config and arm a capture.
REQ-007 abort  in  1  stop any capture and return to idle.
REQ-008 continuous  in  1  mode select, sampled at restart: 0 = one block, 1 = repeat blocks.
REQ-009 n_periods  in  NPER_WIDTH  periods per block, sampled at restart; 0 SHALL be treated as 1.
REQ-010 count_max  in  ADDR_WIDTH  last address of a period, sampled at restart.
REQ-011 address  in  ADDR_WIDTH  free-running reference address; sync source.
REQ-012 wen  out  1  BRAM write enable, high in RUN.
REQ-013 count  out  ADDR_WIDTH  write address within the current period.
REQ-014 period_idx  out  NPER_WIDTH  index of the current period within the block.
REQ-015 first  out  1  high for all of period_idx==0 while wen; marks accumulator clear.
REQ-016 init  out  1  one-cycle pulse, INIT_LEAD cycles before each period end.
REQ-017 done  out  1  one-cycle pulse when a block completes.
REQ-018 busy  out  1  high in ARM or RUN.

Function
REQ-019 Three states SHALL exist: IDLE, ARM, RUN; all outputs SHALL be registered.
REQ-020 restart in any state SHALL latch count_max, n_periods, continuous into cm_reg, np_reg, cont_reg and enter ARM next cycle, with wen=0, count=0, period_idx=0.
REQ-021 abort SHALL enter IDLE next cycle with wen=0; abort and restart in the same cycle: abort wins.
REQ-022 In ARM, an edge with address==cm_reg SHALL enter RUN with count=0, period_idx=0, wen=1; wen/count=0 are thus visible the cycle after address==cm_reg.
REQ-023 In RUN, count SHALL increment by 1 each cycle while count!=cm_reg.
REQ-024 At count==cm_reg with period_idx<np_reg-1, next cycle SHALL be count=0, period_idx+1, wen held 1 (no gap).
REQ-025 At count==cm_reg with period_idx==np_reg-1: done SHALL pulse next cycle; cont_reg=0 -> IDLE, wen=0, count held at cm_reg; cont_reg=1 -> stay RUN, count=0, period_idx=0.
REQ-026 init SHALL be high exactly in the cycle where wen=1 and count==cm_reg-INIT_LEAD; if cm_reg<INIT_LEAD init SHALL never assert.
REQ-027 first SHALL equal wen AND period_idx==0.
REQ-028 cm_reg=0 SHALL give one-cycle periods; wen stays high n_periods cycles.
REQ-029 count and period_idx SHALL never exceed cm_reg and np_reg-1; no wrap beyond these.
REQ-030 busy SHALL be 1 in ARM and RUN, 0 in IDLE; done SHALL not assert after abort.
REQ-031 Changes to count_max/n_periods/continuous outside a restart cycle SHALL have no effect.

Reset
REQ-032 rst SHALL force IDLE and wen=0, count=0, period_idx=0, first=0, init=0, done=0, busy=0, cm_reg=0, np_reg=1, cont_reg=0; rst overrides restart and abort.
REQ-033 rst mid-RUN SHALL drop wen the next cycle with no done pulse.

Verification
REQ-034 count_max=7, n_periods=1, continuous=0, address free-running 0..7, restart -> wen high 8 cycles after address==7, count 0..7, init at count=5, done once, busy falls.
REQ-035 count_max=3, n_periods=3 -> wen high 12 contiguous cycles, period_idx 0,0,0,0,1..1,2..2, first high for first 4, init 3 times, one done.
REQ-036 continuous=1, count_max=3, n_periods=2 -> done every 8 cycles, wen never drops; abort -> wen 0 next cycle, no further done.
REQ-037 count_max=1, INIT_LEAD=2 -> init never asserts; count_max=0, n_periods=0 -> wen high exactly 1 cycle, done once.
REQ-038 restart during RUN with count_max changed 7->15 -> wen drops, re-arms, new block syncs on address==15, count 0..15.
REQ-039 rst asserted mid-period and together with restart -> all outputs 0 next cycle, state IDLE.
